// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the subordinate family.
// Transfer/size encodings, response codes and the subordinate FSM state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3,
      HSIZE_4W    = 3'd4,
      HSIZE_8W    = 3'd5,
      HSIZE_16W   = 3'd6,
      HSIZE_32W   = 3'd7
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef logic [1:0] sub_state_t;
   localparam sub_state_t S_IDLE = 2'd0;
   localparam sub_state_t S_WAIT = 2'd1;
   localparam sub_state_t S_ERR1 = 2'd2;
   localparam sub_state_t S_ERR2 = 2'd3;

   // NONSEQ and SEQ are the only transfer types that start a data phase.
   function automatic logic is_active(input htrans_t t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_subordinate_byte_strobe.sv
// Little-endian byte-lane enables from the low address bits and transfer size.
// Lanes whose index falls in the same naturally-aligned 2**size block as the address are enabled.
module ahb_subordinate_byte_strobe #(
   parameter  int DATA_WDT = 32,
   localparam int BYTES    = DATA_WDT / 8,
   localparam int OFF_W    = $clog2(BYTES)
) (
   input  logic [OFF_W-1:0] i_addr_lo,
   input  logic [2:0]       i_size,
   output logic [BYTES-1:0] o_strobe
);

   always_comb begin
      o_strobe = '0;
      for (int i = 0; i < BYTES; i++) begin
         o_strobe[i] = ((i >> i_size) == (int'(i_addr_lo) >> i_size));
      end
   end

endmodule

// File: rtl/ahb_subordinate_ram.sv
// AHB-Lite subordinate backed by a word-addressed RAM, with configurable
// wait states on OKAY data phases and the two-cycle ERROR response.
module ahb_subordinate_ram
   import ahb_pkg::*;
#(
   parameter int DATA_WDT    = 32,
   parameter int ADDR_WDT    = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                i_clk,
   input  logic                i_resetn,
   input  logic                i_hsel,
   input  logic [ADDR_WDT-1:0] i_haddr,
   input  logic [1:0]          i_htrans,
   input  logic                i_hwrite,
   input  logic [2:0]          i_hsize,
   input  logic [DATA_WDT-1:0] i_hwdata,
   input  logic                i_hready,
   output logic                o_hreadyout,
   output logic                o_hresp,
   output logic [DATA_WDT-1:0] o_hrdata
);

   localparam int         BYTES    = DATA_WDT / 8;
   localparam int         OFF_W    = $clog2(BYTES);
   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   logic [DATA_WDT-1:0] mem [DEPTH_WORDS];

   sub_state_t       state_q, state_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic             dp_valid_q, dp_valid_d;
   logic             dp_write_q, dp_write_d;
   logic [2:0]       dp_size_q, dp_size_d;
   logic [OFF_W-1:0] dp_lo_q, dp_lo_d;
   logic [IDX_W-1:0] dp_idx_q, dp_idx_d;

   logic                ready, complete, accept;
   logic                misaligned, out_of_range, req_err;
   logic [ADDR_WDT-1:0] align_mask;
   logic [BYTES-1:0]    strobe;

   // Only S_IDLE and S_ERR2 end a data phase, so only they sample address phases.
   assign ready    = (state_q == S_IDLE) || (state_q == S_ERR2);
   assign complete = (state_q == S_IDLE) && dp_valid_q;
   assign accept   = i_hsel && i_hready && is_active(htrans_t'(i_htrans)) && ready;

   assign align_mask   = (ADDR_WDT'(1) << i_hsize) - ADDR_WDT'(1);
   assign misaligned   = |(i_haddr & align_mask);
   assign out_of_range = (i_haddr >> (IDX_W + OFF_W)) != '0;
   assign req_err      = (i_hsize > MAX_SIZE) || misaligned || out_of_range;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_size_d  = dp_size_q;
      dp_lo_d    = dp_lo_q;
      dp_idx_d   = dp_idx_q;
      case (state_q)
         S_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) state_d = S_IDLE;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d    = S_IDLE;
            dp_valid_d = 1'b0;
            if (accept) begin
               dp_write_d = i_hwrite;
               dp_size_d  = i_hsize;
               dp_lo_d    = i_haddr[OFF_W-1:0];
               dp_idx_d   = i_haddr[OFF_W +: IDX_W];
               if (req_err) begin
                  state_d = S_ERR1;
               end else begin
                  dp_valid_d = 1'b1;
                  if (WAIT_CNT != 4'd0) begin
                     state_d = S_WAIT;
                     wcnt_d  = WAIT_CNT;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_size_q  <= '0;
         dp_lo_q    <= '0;
         dp_idx_q   <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_size_q  <= dp_size_d;
         dp_lo_q    <= dp_lo_d;
         dp_idx_q   <= dp_idx_d;
      end
   end

   ahb_subordinate_byte_strobe #(.DATA_WDT(DATA_WDT)) u_strobe (
      .i_addr_lo (dp_lo_q),
      .i_size    (dp_size_q),
      .o_strobe  (strobe)
   );

   // Reset clears dp_valid_q asynchronously, so an abandoned write never commits.
   always_ff @(posedge i_clk) begin
      if (complete && dp_write_q) begin
         for (int b = 0; b < BYTES; b++) begin
            if (strobe[b]) mem[dp_idx_q][b*8 +: 8] <= i_hwdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      o_hreadyout = ready;
      o_hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      o_hrdata    = (complete && !dp_write_q) ? mem[dp_idx_q] : '0;
   end

endmodule

// File: tb/tb_ahb_subordinate_ram.sv
// Bench for ahb_subordinate_ram: a zero-wait and a three-wait instance driven
// cycle by cycle, checked against a byte-array memory and data-phase length model.
module tb_ahb_subordinate_ram;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        a_hsel, a_hwrite, a_hready, a_hreadyout, a_hresp;
   logic [31:0] a_haddr, a_hwdata, a_hrdata;
   logic [1:0]  a_htrans;
   logic [2:0]  a_hsize;
   logic        b_hsel, b_hwrite, b_hready, b_hreadyout, b_hresp;
   logic [31:0] b_haddr, b_hwdata, b_hrdata;
   logic [1:0]  b_htrans;
   logic [2:0]  b_hsize;

   ahb_subordinate_ram #(.DATA_WDT(32), .ADDR_WDT(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
      .i_clk(clk), .i_resetn(rst_n), .i_hsel(a_hsel), .i_haddr(a_haddr), .i_htrans(a_htrans),
      .i_hwrite(a_hwrite), .i_hsize(a_hsize), .i_hwdata(a_hwdata), .i_hready(a_hready),
      .o_hreadyout(a_hreadyout), .o_hresp(a_hresp), .o_hrdata(a_hrdata)
   );

   ahb_subordinate_ram #(.DATA_WDT(32), .ADDR_WDT(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
      .i_clk(clk), .i_resetn(rst_n), .i_hsel(b_hsel), .i_haddr(b_haddr), .i_htrans(b_htrans),
      .i_hwrite(b_hwrite), .i_hsize(b_hsize), .i_hwdata(b_hwdata), .i_hready(b_hready),
      .o_hreadyout(b_hreadyout), .o_hresp(b_hresp), .o_hrdata(b_hrdata)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Model: data-phase cycles remaining for the transfer in flight, plus a byte image of each RAM.
   int          dp_left [2];
   bit          ph_err  [2];
   bit          ph_wr   [2];
   logic [31:0] ph_addr [2];
   logic [2:0]  ph_sz   [2];
   logic [31:0] ph_wd   [2];
   logic [7:0]  mm      [2][4096];

   logic        last_rdy, last_resp;
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mword(input int s, input logic [31:0] a);
      int b;
      b = int'(a) & ~3;
      return {mm[s][b+3], mm[s][b+2], mm[s][b+1], mm[s][b]};
   endfunction

   function automatic bit model_err(input logic [2:0] sz, input logic [31:0] a);
      return (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0) || (a >= 32'd4096);
   endfunction

   // One bus cycle: present an address phase, check the current data phase, advance over the edge.
   task automatic cyc(input int s, input logic hs, input logic hr, input logic [1:0] tr,
                      input logic wr, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      logic        e_rdy, e_resp, o_rdy, o_resp;
      logic [31:0] e_rd, o_rd;
      if (s == 0) begin
         a_hsel = hs; a_hready = hr; a_htrans = tr; a_hwrite = wr; a_hsize = sz; a_haddr = ad; a_hwdata = ph_wd[0];
      end else begin
         b_hsel = hs; b_hready = hr; b_htrans = tr; b_hwrite = wr; b_hsize = sz; b_haddr = ad; b_hwdata = ph_wd[1];
      end
      #1;
      e_rdy  = (dp_left[s] <= 1);
      e_resp = (dp_left[s] > 0) && ph_err[s];
      e_rd   = (dp_left[s] == 1 && !ph_err[s] && !ph_wr[s]) ? mword(s, ph_addr[s]) : 32'd0;
      o_rdy  = (s == 0) ? a_hreadyout : b_hreadyout;
      o_resp = (s == 0) ? a_hresp : b_hresp;
      o_rd   = (s == 0) ? a_hrdata : b_hrdata;
      chk("hreadyout", 32'(o_rdy), 32'(e_rdy));
      chk("hresp", 32'(o_resp), 32'(e_resp));
      chk("hrdata", o_rd, e_rd);
      last_rdy = o_rdy; last_resp = o_resp; last_rd = o_rd;
      if (dp_left[s] > 1) begin
         dp_left[s]--;
      end else begin
         if (dp_left[s] == 1 && !ph_err[s] && ph_wr[s]) begin
            for (int k = 0; k < (1 << ph_sz[s]); k++) begin
               int ba;
               ba = int'(ph_addr[s]) + k;
               mm[s][ba] = ph_wd[s][8*(ba % 4) +: 8];
            end
         end
         if (hs && hr && (tr == 2'd2 || tr == 2'd3)) begin
            ph_err[s]  = model_err(sz, ad);
            ph_wr[s]   = wr;
            ph_addr[s] = ad;
            ph_sz[s]   = sz;
            ph_wd[s]   = wd;
            dp_left[s] = ph_err[s] ? 2 : (1 + ((s == 0) ? 0 : 3));
         end else begin
            dp_left[s] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int s, input int n);
      repeat (n) cyc(s, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   // Holds the address phase until the edge that accepts it.
   task automatic xfer(input int s, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd);
      bit rdy;
      for (int g = 0; g < 20; g++) begin
         rdy = (dp_left[s] <= 1);
         cyc(s, 1'b1, 1'b1, tr, wr, sz, ad, wd);
         if (rdy) break;
      end
   endtask

   // Idles until the data phase in flight reports ready; last_* then hold that cycle.
   task automatic until_done(input int s);
      for (int g = 0; g < 20; g++) begin
         cyc(s, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0);
         if (last_rdy) break;
      end
   endtask

   initial begin
      int          lows;
      logic [31:0] exp_w;
      logic [31:0] ad;
      logic [2:0]  sz;
      int          r;

      for (int s = 0; s < 2; s++) begin
         dp_left[s] = 0; ph_err[s] = 0; ph_wr[s] = 0;
         ph_addr[s] = '0; ph_sz[s] = '0; ph_wd[s] = '0;
      end
      a_hsel = 0; a_hready = 1; a_htrans = 0; a_hwrite = 0; a_hsize = 0; a_haddr = 0; a_hwdata = 0;
      b_hsel = 0; b_hready = 1; b_htrans = 0; b_hwrite = 0; b_hsize = 0; b_haddr = 0; b_hwdata = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_ready0", 32'(a_hreadyout), 32'd1);
      chk("rst_resp0", 32'(a_hresp), 32'd0);
      chk("rst_rdata0", a_hrdata, 32'd0);
      chk("rst_ready3", 32'(b_hreadyout), 32'd1);
      chk("rst_resp3", 32'(b_hresp), 32'd0);
      chk("rst_rdata3", b_hrdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Prefill both RAMs (low 256 bytes and the last word) with pipelined writes.
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k <= 64; k++) begin
            xfer(s, (k == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, (k < 64) ? 32'(k * 4) : 32'hFFC, $urandom);
         end
         idle(s, 5);
      end

      xfer(0, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
      xfer(0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      idle(0, 1);
      chk("default_read", last_rd, 32'hDEAD_BEEF);
      idle(0, 1);

      xfer(0, 2'd2, 1'b1, 3'd2, 32'h10, 32'h1122_3344);
      xfer(0, 2'd2, 1'b1, 3'd0, 32'h13, 32'hAA00_0000);
      xfer(0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      idle(0, 1);
      chk("byte_write", last_rd, 32'hAA22_3344);
      idle(0, 1);

      xfer(0, 2'd2, 1'b0, 3'd2, 32'h1000, 32'h0);
      idle(0, 1);
      chk("oor_c1_ready", 32'(last_rdy), 32'd0);
      chk("oor_c1_resp", 32'(last_resp), 32'd1);
      idle(0, 1);
      chk("oor_c2_ready", 32'(last_rdy), 32'd1);
      chk("oor_c2_resp", 32'(last_resp), 32'd1);
      chk("oor_c2_rdata", last_rd, 32'd0);
      idle(0, 1);
      xfer(0, 2'd2, 1'b1, 3'd1, 32'h11, 32'h0);
      idle(0, 1);
      chk("misal_c1_resp", 32'(last_resp), 32'd1);
      idle(0, 2);
      xfer(0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      idle(0, 1);
      chk("err_ram_kept", last_rd, 32'hAA22_3344);
      idle(0, 1);

      xfer(0, 2'd2, 1'b1, 3'd2, 32'h0, 32'hA0A0_0001);
      xfer(0, 2'd3, 1'b1, 3'd2, 32'h4, 32'hB0B0_0002);
      xfer(0, 2'd3, 1'b1, 3'd2, 32'h8, 32'hC0C0_0003);
      cyc(0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 32'hC, 32'hDEAD_0000);
      cyc(0, 1'b1, 1'b1, 2'd0, 1'b1, 3'd2, 32'h0, 32'hDEAD_0001);
      xfer(0, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
      xfer(0, 2'd3, 1'b0, 3'd2, 32'h4, 32'h0);
      chk("b2b_read0", last_rd, 32'hA0A0_0001);
      xfer(0, 2'd3, 1'b0, 3'd2, 32'h8, 32'h0);
      chk("b2b_read4", last_rd, 32'hB0B0_0002);
      idle(0, 1);
      chk("b2b_read8", last_rd, 32'hC0C0_0003);

      cyc(0, 1'b1, 1'b0, 2'd2, 1'b1, 3'd2, 32'h20, 32'hFFFF_0000);
      idle(0, 1);
      xfer(0, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
      idle(0, 2);

      xfer(1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      exp_w = mword(1, 32'h10);
      lows = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h14, 32'h0);
         if (last_rdy) break;
         lows++;
      end
      chk("wait_low_cycles", 32'(lows), 32'd3);
      chk("wait_read_data", last_rd, exp_w);
      idle(1, 6);

      exp_w = mword(1, 32'h40);
      xfer(1, 2'd2, 1'b1, 3'd2, 32'h40, ~exp_w);
      idle(1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(b_hreadyout), 32'd1);
      chk("midrst_resp", 32'(b_hresp), 32'd0);
      chk("midrst_rdata", b_hrdata, 32'd0);
      dp_left[0] = 0;
      dp_left[1] = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      xfer(1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
      until_done(1);
      chk("reset_no_write", last_rd, exp_w);
      idle(1, 2);

      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 80; n++) begin
            r  = int'($urandom_range(0, 9));
            ad = (r == 0) ? 32'hFFC + 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 255));
            sz = (r == 1) ? 3'd3 : 3'($urandom_range(0, 2));
            cyc(s, ($urandom_range(0, 7) != 0), 1'b1, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), sz, ad, $urandom);
         end
         idle(s, 6);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
